// File: rtl/inst_loader.sv
// inst_loader: writes a framed byte stream into instruction memory and holds
// the CPU in reset until a complete frame with a good checksum has loaded.
//
// Frame: LEN_LO, LEN_HI (word count N), N*4 data bytes (little-endian words),
// CSUM (XOR of every byte from LEN_LO through the last data byte).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a new frame (honoured only in IDLE/DONE/ERR)
//   s_valid, s_data   byte stream input
//   s_ready           loader accepts a byte this cycle (decoded from state)
//   mem_we            one-cycle write strobe per assembled word
//   mem_addr          word address of the write (holds between writes)
//   mem_wdata         word written (holds between writes)
//   cpu_hold          1 = keep CPU in reset; low only in DONE
//   done, err         frame accepted / rejected (levels)
//   words_loaded      words written in the current/last frame
module inst_loader #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state, state_n;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_next;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic [7:0]  csum;
    logic        xfer;
    logic        start_ok;
    logic        too_big;
    logic        last_word;

    assign xfer     = s_valid && s_ready;
    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign len_next = {s_data, len_lo};
    // Widen to 32 bits so 2**ADDR_W is representable even when ADDR_W == 16.
    assign too_big   = 32'(len_next) > (32'd1 << ADDR_W);
    // words_loaded counts completed words, so it doubles as the word index.
    assign last_word = (32'(words_loaded) + 32'd1) == 32'(len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_ready  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            S_IDLE: begin
                if (start_ok) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                s_ready = 1'b1;
                if (xfer) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                s_ready = 1'b1;
                if (xfer) begin
                    if (too_big)               state_n = S_ERR;
                    else if (len_next == 16'd0) state_n = S_CSUM;
                    else                       state_n = S_DATA;
                end
            end
            S_DATA: begin
                s_ready = 1'b1;
                if (xfer && byte_cnt == 2'd3 && last_word) state_n = S_CSUM;
            end
            S_CSUM: begin
                s_ready = 1'b1;
                if (xfer) state_n = (s_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start_ok) state_n = S_LEN_LO;
            end
            S_ERR: begin
                err = 1'b1;
                if (start_ok) state_n = S_LEN_LO;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Byte assembler and write register are separate, so the next word's
    // bytes keep flowing while the previous word is being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo       <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            csum         <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                csum         <= '0;
                byte_cnt     <= '0;
                words_loaded <= '0;
            end
            if (xfer) begin
                case (state)
                    S_LEN_LO: begin
                        len_lo <= s_data;
                        csum   <= csum ^ s_data;
                    end
                    S_LEN_HI: begin
                        len  <= len_next;
                        csum <= csum ^ s_data;
                    end
                    S_DATA: begin
                        csum     <= csum ^ s_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_q[7:0]   <= s_data;
                            2'd1: asm_q[15:8]  <= s_data;
                            2'd2: asm_q[23:16] <= s_data;
                            default: begin
                                mem_we       <= 1'b1;
                                mem_addr     <= words_loaded[ADDR_W-1:0];
                                mem_wdata    <= {s_data, asm_q};
                                words_loaded <= words_loaded + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_valid4 = 1'b0;
    logic [7:0]  s_data = '0;

    logic        s_ready, mem_we, cpu_hold, done, err;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [12:0] words_loaded;

    logic        s_ready4, mem_we4, cpu_hold4, done4, err4;
    logic [3:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [4:0]  words_loaded4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inst_loader #(.ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    inst_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .s_valid(s_valid4), .s_data(s_data),
        .s_ready(s_ready4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .cpu_hold(cpu_hold4), .done(done4), .err(err4), .words_loaded(words_loaded4)
    );

    // Write logs, sampled on the falling edge; counts only ever increase.
    int          nw = 0;
    int          nw4 = 0;
    logic [11:0] wa [256];
    logic [31:0] wd [256];
    logic [3:0]  wa4 [256];
    logic [31:0] wd4 [256];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa[nw % 256] = mem_addr;
            wd[nw % 256] = mem_wdata;
            nw = nw + 1;
        end
        if (mem_we4 === 1'b1) begin
            wa4[nw4 % 256] = mem_addr4;
            wd4[nw4 % 256] = mem_wdata4;
            nw4 = nw4 + 1;
        end
    end

    typedef struct {
        logic [0:15][7:0] b;
        int               n;
        bit               gaps;
        bit               exp_done;
        int               exp_words;
        int               exp_nw;
        logic [31:0]      w0;
        logic [31:0]      w1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start4 = 1'b1; else start = 1'b1;
        tick();
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    // Presents one byte and holds it until it transfers (bounded wait).
    task automatic send(input bit sel, input logic [7:0] b, input int gap);
        logic rdy;
        bit   fin;
        int   k;
        for (int g = 0; g < gap; g++) begin
            s_valid  = 1'b0;
            s_valid4 = 1'b0;
            tick();
        end
        s_data = b;
        if (sel) s_valid4 = 1'b1; else s_valid = 1'b1;
        fin = 1'b0;
        k = 0;
        while (!fin) begin
            rdy = sel ? s_ready4 : s_ready;
            tick();
            if (rdy) begin
                fin = 1'b1;
            end else begin
                k++;
                if (k > 50) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout: got no s_ready expected s_ready within 50 cycles");
                    fin = 1'b1;
                end
            end
        end
    endtask

    task automatic run_vec(input int i);
        int base;
        base = nw;
        pulse_start(1'b0);
        chk($sformatf("v%0d_hold_on_start", i), 32'(cpu_hold), 32'd1);
        for (int j = 0; j < vecs[i].n; j++)
            send(1'b0, vecs[i].b[j], vecs[i].gaps ? int'($urandom_range(0, 3)) : 0);
        s_valid = 1'b0;
        // Result is visible in the cycle right after the CSUM transfer.
        chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
        chk($sformatf("v%0d_err", i), 32'(err), 32'(!vecs[i].exp_done));
        chk($sformatf("v%0d_cpu_hold", i), 32'(cpu_hold), 32'(!vecs[i].exp_done));
        chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'd0);
        chk($sformatf("v%0d_words", i), 32'(words_loaded), 32'(vecs[i].exp_words));
        tick();
        tick();
        chk($sformatf("v%0d_nwrites", i), 32'(nw - base), 32'(vecs[i].exp_nw));
        chk($sformatf("v%0d_done_level", i), 32'(done), 32'(vecs[i].exp_done));
        if (vecs[i].exp_nw >= 1) begin
            chk($sformatf("v%0d_addr0", i), 32'(wa[base % 256]), 32'd0);
            chk($sformatf("v%0d_data0", i), wd[base % 256], vecs[i].w0);
        end
        if (vecs[i].exp_nw >= 2) begin
            chk($sformatf("v%0d_addr1", i), 32'(wa[(base + 1) % 256]), 32'd1);
            chk($sformatf("v%0d_data1", i), wd[(base + 1) % 256], vecs[i].w1);
        end
    endtask

    initial begin
        logic [0:15][7:0] f1;
        logic [7:0]       cs;
        logic [31:0]      w;
        int               base;

        f1 = 128'h02_00_13_00_00_00_93_00_10_00_92_00_00_00_00_00;
        vecs[0] = '{f1, 11, 1'b0, 1'b1, 2, 2, 32'h0000_0013, 32'h0010_0093};
        vecs[1] = '{128'h02_00_13_00_00_00_93_00_10_00_93_00_00_00_00_00,
                    11, 1'b0, 1'b0, 2, 2, 32'h0000_0013, 32'h0010_0093};
        vecs[2] = '{128'h00_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00,
                    3, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0};
        vecs[3] = '{f1, 11, 1'b1, 1'b1, 2, 2, 32'h0000_0013, 32'h0010_0093};
        vecs[4] = '{128'h01_00_EF_BE_AD_DE_23_00_00_00_00_00_00_00_00_00,
                    7, 1'b1, 1'b1, 1, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[5] = '{128'h00_00_01_00_00_00_00_00_00_00_00_00_00_00_00_00,
                    3, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        tick();
        chk("idle_s_ready", 32'(s_ready), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset one cycle after the 5th byte: frame abandoned, no write appears.
        pulse_start(1'b0);
        for (int j = 0; j < 5; j++) send(1'b0, f1[j], 0);
        s_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = nw;
        chk("rst5_s_ready", 32'(s_ready), 32'd0);
        chk("rst5_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst5_done", 32'(done), 32'd0);
        chk("rst5_words", 32'(words_loaded), 32'd0);
        repeat (5) tick();
        chk("rst5_no_write", 32'(nw - base), 32'd0);

        // Reset during the write cycle clears the write register.
        pulse_start(1'b0);
        for (int j = 0; j < 6; j++) send(1'b0, f1[j], 0);
        s_valid = 1'b0;
        chk("we_latency", 32'(mem_we), 32'd1);
        chk("we_addr", 32'(mem_addr), 32'd0);
        chk("we_data", mem_wdata, 32'h0000_0013);
        chk("we_words", 32'(words_loaded), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_mem_we", 32'(mem_we), 32'd0);
        chk("rstw_mem_addr", 32'(mem_addr), 32'd0);
        chk("rstw_mem_wdata", mem_wdata, 32'd0);
        chk("rstw_words", 32'(words_loaded), 32'd0);

        run_vec(0);

        // start in the middle of a frame is ignored.
        base = nw;
        pulse_start(1'b0);
        for (int j = 0; j < 4; j++) send(1'b0, f1[j], 0);
        s_valid = 1'b0;
        pulse_start(1'b0);
        for (int j = 4; j < 11; j++) send(1'b0, f1[j], 0);
        s_valid = 1'b0;
        chk("midstart_done", 32'(done), 32'd1);
        chk("midstart_words", 32'(words_loaded), 32'd2);
        tick();
        chk("midstart_nwrites", 32'(nw - base), 32'd2);

        // ADDR_W=4: N=17 rejected right after LEN_HI.
        base = nw4;
        pulse_start(1'b1);
        send(1'b1, 8'h11, 0);
        send(1'b1, 8'h00, 0);
        s_valid4 = 1'b0;
        chk("big_err", 32'(err4), 32'd1);
        chk("big_done", 32'(done4), 32'd0);
        chk("big_s_ready", 32'(s_ready4), 32'd0);
        chk("big_cpu_hold", 32'(cpu_hold4), 32'd1);
        repeat (3) tick();
        chk("big_no_write", 32'(nw4 - base), 32'd0);

        pulse_start(1'b1);
        chk("recover_err_clr", 32'(err4), 32'd0);
        for (int j = 0; j < 11; j++) send(1'b1, f1[j], 0);
        s_valid4 = 1'b0;
        chk("recover_done", 32'(done4), 32'd1);
        chk("recover_words", 32'(words_loaded4), 32'd2);
        tick();
        chk("recover_nwrites", 32'(nw4 - base), 32'd2);

        // ADDR_W=4: N=16 fills the memory exactly and is accepted.
        base = nw4;
        pulse_start(1'b1);
        cs = 8'h10;
        send(1'b1, 8'h10, 0);
        send(1'b1, 8'h00, 0);
        for (int k = 0; k < 16; k++) begin
            w = 32'h1000_0000 + 32'(k);
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ w[8*j +: 8];
                send(1'b1, w[8*j +: 8], 0);
            end
        end
        send(1'b1, cs, 0);
        s_valid4 = 1'b0;
        chk("full_done", 32'(done4), 32'd1);
        chk("full_words", 32'(words_loaded4), 32'd16);
        chk("full_cpu_hold", 32'(cpu_hold4), 32'd0);
        tick();
        chk("full_nwrites", 32'(nw4 - base), 32'd16);
        chk("full_last_addr", 32'(wa4[(base + 15) % 256]), 32'd15);
        chk("full_last_data", wd4[(base + 15) % 256], 32'h1000_000F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
